// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: TileLink-UL field widths, opcode constants and channel
// structs shared by the RAM arbiter, its interface and its users.
package ram_arbiter_pkg;

    localparam int TL_AW = 32;   // address width
    localparam int TL_DW = 64;   // data width
    localparam int TL_MW = 8;    // byte-mask width
    localparam int TL_SW = 3;    // log2(bytes) size field width
    localparam int TL_OW = 3;    // opcode width

    // A-channel opcodes
    localparam logic [2:0] TL_PUT_F = 3'd0;
    localparam logic [2:0] TL_PUT_P = 3'd1;
    localparam logic [2:0] TL_GET   = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

endpackage

// File: rtl/ram_arbiter_if.sv
// tilelink: TileLink-UL A and D channels.
//   master modport : drives A request fields and d_ready, receives a_ready and D response
//   slave  modport : the mirror view
interface tilelink;
    import ram_arbiter_pkg::*;

    logic             a_valid;
    logic             a_ready;
    logic [TL_OW-1:0] a_opcode;
    logic [TL_SW-1:0] a_size;
    logic [TL_AW-1:0] a_address;
    logic [TL_MW-1:0] a_mask;
    logic [TL_DW-1:0] a_data;

    logic             d_valid;
    logic             d_ready;
    logic [TL_OW-1:0] d_opcode;
    logic [TL_DW-1:0] d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_data
    );

endinterface

// File: rtl/ram_arbiter_pick.sv
// rr_pick2: combinational two-way winner selection.
//   req[1:0] : pending requests (bit i = requester i)
//   prio     : index preferred when both request (used only when FAIR=1)
//   gnt_idx  : winning index
//   gnt_vld  : at least one request pending
module rr_pick2 #(
    parameter bit FAIR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    // Lone requester always wins; a tie goes to prio (FAIR) or to requester 0.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = FAIR ? prio : 1'b0;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one TileLink-UL RAM slave between a fetch port (m0)
// and a load/store port (m1), one transaction in flight at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : requester ports (slave view)
//   ram        : RAM port (master view)
//   owner      : granted requester, meaningful while busy
//   busy       : a transaction is in flight
// Grant is registered in IDLE; the A and D paths are pure muxes selected by
// the registered state and owner, so a D beat right after the A handshake
// is accepted in that same cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    tilelink.slave  m0,
    tilelink.slave  m1,
    tilelink.master ram,
    output logic    owner,
    output logic    busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_r;
    logic   owner_r;
    logic   prio_r;
    logic   busy_r;
    logic   gnt_idx_s;
    logic   gnt_vld_s;
    logic   a_hs_s;
    logic   d_hs_s;

    rr_pick2 #(.FAIR(FAIR)) u_pick (
        .req     ({m1.a_valid, m0.a_valid}),
        .prio    (prio_r),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    // A and D channel routing; everything idles at zero outside its state.
    always_comb begin
        ram.a_valid   = 1'b0;
        ram.a_opcode  = 3'd0;
        ram.a_size    = 3'd0;
        ram.a_address = 32'd0;
        ram.a_mask    = 8'd0;
        ram.a_data    = 64'd0;
        ram.d_ready   = 1'b0;
        m0.a_ready    = 1'b0;
        m1.a_ready    = 1'b0;
        m0.d_valid    = 1'b0;
        m0.d_opcode   = 3'd0;
        m0.d_data     = 64'd0;
        m1.d_valid    = 1'b0;
        m1.d_opcode   = 3'd0;
        m1.d_data     = 64'd0;
        a_hs_s        = 1'b0;
        d_hs_s        = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (owner_r) begin
                    ram.a_valid   = m1.a_valid;
                    ram.a_opcode  = m1.a_opcode;
                    ram.a_size    = m1.a_size;
                    ram.a_address = m1.a_address;
                    ram.a_mask    = m1.a_mask;
                    ram.a_data    = m1.a_data;
                    m1.a_ready    = ram.a_ready;
                    a_hs_s        = m1.a_valid & ram.a_ready;
                end else begin
                    ram.a_valid   = m0.a_valid;
                    ram.a_opcode  = m0.a_opcode;
                    ram.a_size    = m0.a_size;
                    ram.a_address = m0.a_address;
                    ram.a_mask    = m0.a_mask;
                    ram.a_data    = m0.a_data;
                    m0.a_ready    = ram.a_ready;
                    a_hs_s        = m0.a_valid & ram.a_ready;
                end
            end
            ST_RESP: begin
                if (owner_r) begin
                    m1.d_valid  = ram.d_valid;
                    m1.d_opcode = ram.d_opcode;
                    m1.d_data   = ram.d_data;
                    ram.d_ready = m1.d_ready;
                    d_hs_s      = ram.d_valid & m1.d_ready;
                end else begin
                    m0.d_valid  = ram.d_valid;
                    m0.d_opcode = ram.d_opcode;
                    m0.d_data   = ram.d_data;
                    ram.d_ready = m0.d_ready;
                    d_hs_s      = ram.d_valid & m0.d_ready;
                end
            end
            default: begin
                a_hs_s = 1'b0;
                d_hs_s = 1'b0;
            end
        endcase
    end

    // Grant FSM: latch winner in IDLE, hold it until the D handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_vld_s) begin
                        owner_r <= gnt_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (a_hs_s) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (d_hs_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        // Prefer the other requester next time.
                        prio_r  <= FAIR ? ~owner_r : prio_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester TileLink-UL arbiter that shares the single RAM slave between the instruction-fetch port (m0) and the load/store port (m1). It sits directly in front of the RAM and presents one `tilelink` master view to it. It grants round-robin, holds exactly one transaction in flight, and routes the D-channel response back to the owning requester. It exports `owner` and `busy` so the RAM debug monitor can tag its trace lines.

## Interface

Parameters:
- `FAIR`, default 1: 1 = round-robin; 0 = fixed priority, m0 wins.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `m0`  tilelink.slave  -  requester 0 (fetch)
- `m1`  tilelink.slave  -  requester 1 (load/store)
- `ram`  tilelink.master  -  to RAM slave
- `owner`  out  1  index of granted requester; valid while `busy`
- `busy`  out  1  transaction in flight (state != IDLE)

TileLink fields used on all three interfaces:
- A channel: `a_valid`, `a_ready`, `a_opcode`, `a_size`, `a_address`, `a_mask`, `a_data`.
- D channel: `d_valid`, `d_ready`, `d_opcode`, `d_data`.

## Operation

State machine with three states:
- IDLE
  - No grant held.
  - Sample `m0.a_valid` and `m1.a_valid`.
  - If either is set, pick a winner, latch it into `owner` and go to REQ.
- REQ
  - The winner's A fields are muxed onto `ram.a_*`.
  - `ram.a_valid` = winner's `a_valid`.
  - Winner's `a_ready` = `ram.a_ready`; loser's `a_ready` = 0.
  - On `ram.a_valid & ram.a_ready`, go to RESP.
- RESP
  - `ram.d_*` is routed to the owner's D channel.
  - Non-owner `d_valid` = 0.
  - `ram.d_ready` = owner's `d_ready`.
  - On `ram.d_valid & ram.d_ready`, go to IDLE.
  - If FAIR, the round-robin pointer updates here to prefer the other requester.

Arbitration rules:
- Round-robin pointer `prio` (1 bit) = index to prefer on a tie.
- Single requester: it wins regardless of `prio`.
- Both requesting:
  - FAIR=1: the `prio` index wins.
  - FAIR=0: m0 wins.
- Once granted, the grant is held through the response even if the requester drops `a_valid` in REQ. Requesters must not drop `a_valid` (TileLink rule). If they do, the arbiter stays in REQ.
- Opcodes (`TL_GET`, `TL_PUT_F`, `TL_PUT_P`) pass through unmodified. The arbiter does not decode them and accepts any D opcode (`TL_ACCESS_ACK`, `TL_ACCESS_ACK_DATA`).
- When not in REQ, both `m*.a_ready` = 0 and `ram.a_valid` = 0.
- When not in RESP, both `m*.d_valid` = 0 and `ram.d_ready` = 0.

## Timing

Reset values:
- state = IDLE, `prio` = 0, `owner` = 0, `busy` = 0.
- All valid/ready outputs = 0.
- Mux data outputs = 0.

Latency and throughput:
- Request at cycle N in IDLE → `ram.a_valid` high at N+1 (registered grant, one bubble).
- A-handshake at cycle K → RESP from K+1. A D beat at K+1 is accepted that same cycle.
- Minimum transaction is 3 cycles (IDLE, REQ, RESP). Back-to-back transactions for one requester are therefore 3 cycles apart.

Boundary behaviour:
- Simultaneous requests in IDLE: resolved per `prio`; the loser waits in the next IDLE.
- Under FAIR=1 with both requesters continuously requesting, grants strictly alternate.
- A D response arriving while in REQ (protocol error): ignored; `ram.d_ready` stays 0.
- Reset asserted mid-transaction: immediate return to IDLE and reset values. No response is delivered to the owner. Requesters are reset in the same domain.

`owner` and `busy` are registered, with no combinational path from inputs.

## Structure

- Shared package (`tl_pkg` / `isa.vh`) holds the `TL_*` opcode constants. The arbiter uses them only in assertions.
- The state enum (IDLE, REQ, RESP) belongs in `ram_arbiter` itself.
- Natural sub-module: `rr_pick2`, combinational, with inputs `req[1:0]`, `prio`, `FAIR` and outputs `gnt_idx`, `gnt_vld`. Keep the muxing and FSM in the top module.

## Test plan

- **Single GET on m0** to 0x8000_0000, size 3:
  - `ram.a_valid` rises 1 cycle after the request, `owner` = 0.
  - m0 receives `d_data` 0xDEADBEEF_CAFEF00D with `TL_ACCESS_ACK_DATA`.
  - m1 sees no `d_valid`.
- **Simultaneous requests, FAIR=1:** m0 PUT_F 0x10 and m1 GET 0x20 both asserted from reset.
  - Grant order m0, m1, m0, m1 over 4 transactions.
  - Each requester's `a_ready` asserted only in its own REQ.
- **Same stimulus with FAIR=0:** m0 granted every time while it keeps requesting; m1 starves.
- **RAM backpressure:** hold `ram.a_ready` = 0 for 5 cycles, then set `d_ready` = 0 for 3 cycles.
  - Arbiter holds REQ, then RESP, with no state change.
  - A fields stay stable throughout.
  - Completes when both are released.
- **Reset mid-RESP:** pulse `rst_n` low while owner = 1 awaits data.
  - All outputs return to reset values asynchronously.
  - After release, a fresh m0 GET completes normally.
- **Same-cycle handshake:** RAM returns D in the cycle right after the A handshake with `d_ready` = 1.
  - Transaction completes in 3 cycles.
  - `busy` falls on the following cycle.
